// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;
    localparam int DEF_DATA_WIDTH = `DATA_WIDTH;

    // Widths for the default configuration; the top re-derives them from its own parameters.
    localparam int REQ_IDX_W = $clog2(DEF_NUM_REQ);
    localparam int BEAT_W    = $clog2(DEF_MAX_BURST + 1);

endpackage

// File: rtl/fifo_arb_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping cyclically.
// Wrap is an explicit compare so non-power-of-two request counts work.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   pick,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    // Walk every position once starting at ptr; the first hit wins.
    always_comb begin
        idx     = ptr;
        pick    = '0;
        any_req = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_req && req[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
            idx = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Writes are gated by fifo_full, so the FIFO never sees wr_en while full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e      state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   next_ptr;
    logic [BW-1:0]   beat_cnt;
    logic            any_req;
    logic            own_valid;
    logic            wr;
    logic            last_beat;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .pick    (pick),
        .any_req (any_req)
    );

    assign own_valid = req_valid[owner];
    assign wr        = (state == BURST) && own_valid && !fifo_full;
    assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));
    assign next_ptr  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

    // Zero-latency write path: mux the owner's word straight onto the FIFO port.
    always_comb begin
        req_ready   = '0;
        fifo_wr_en  = wr;
        fifo_wdata  = '0;
        grant_valid = (state == BURST);
        grant_id    = '0;
        if (state == BURST) grant_id = owner;
        if (wr) begin
            req_ready[owner] = 1'b1;
            fifo_wdata       = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Grant FSM: one idle cycle to pick, then a burst bounded by MAX_BURST or by the owner going idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (!own_valid) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end else if (wr) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
